// File: rtl/cim_vector_datapath.sv
// Row-serial compute-in-memory vector datapath driving a dual-port SRAM (read A/B, write back on A).
// Define CIM_POPCOUNT_EN to enable opcode 11, the masked popcount reduction.
module cim_vector_datapath #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                          sys_clk_in,
  input  logic                          sys_reset_in,
  input  logic                          cmd_valid_in,
  output logic                          cmd_ready_out,
  input  logic [3:0]                    cmd_op_in,
  input  logic [ADDR_WIDTH-1:0]         cmd_src_a_in,
  input  logic [ADDR_WIDTH-1:0]         cmd_src_b_in,
  input  logic [ADDR_WIDTH-1:0]         cmd_dst_in,
  input  logic [LEN_WIDTH-1:0]          cmd_len_in,
  input  logic [$clog2(DATA_WIDTH)-1:0] cmd_shift_in,
  input  logic [DATA_WIDTH-1:0]         cmd_mask_in,
  output logic [ADDR_WIDTH-1:0]         sram_addr_a_out,
  output logic [ADDR_WIDTH-1:0]         sram_addr_b_out,
  output logic [DATA_WIDTH-1:0]         sram_data_a_out,
  output logic                          sram_wren_a_out,
  input  logic [DATA_WIDTH-1:0]         sram_q_a_in,
  input  logic [DATA_WIDTH-1:0]         sram_q_b_in,
  output logic                          busy_out,
  output logic                          done_out,
  output logic                          error_out,
  output logic [DATA_WIDTH-1:0]         result_out
);

  localparam int SW = $clog2(DATA_WIDTH);

  localparam logic [3:0] OP_OR   = 4'd0;
  localparam logic [3:0] OP_AND  = 4'd1;
  localparam logic [3:0] OP_XOR  = 4'd2;
  localparam logic [3:0] OP_MOV  = 4'd3;
  localparam logic [3:0] OP_NOT  = 4'd4;
  localparam logic [3:0] OP_SHL  = 4'd5;
  localparam logic [3:0] OP_SHR  = 4'd6;
  localparam logic [3:0] OP_ROTL = 4'd7;
  localparam logic [3:0] OP_ADD  = 4'd8;
  localparam logic [3:0] OP_XORR = 4'd9;
  localparam logic [3:0] OP_ANDR = 4'd10;
`ifdef CIM_POPCOUNT_EN
  localparam logic [3:0] OP_POP  = 4'd11;
  localparam logic [3:0] OP_MAX  = 4'd11;
`else
  localparam logic [3:0] OP_MAX  = 4'd10;
`endif

  // Handshake: a command transfers on a rising edge where cmd_valid_in and
  // cmd_ready_out are both high; ready is high only in IDLE and every field is
  // registered at that edge, so the inputs may change freely afterwards.
  typedef enum logic [1:0] {IDLE, RD, EXE, DONE} state_t;
  state_t state, state_nxt;

  logic [3:0]            op_q;
  logic [ADDR_WIDTH-1:0] src_a_q, src_b_q, dst_q;
  logic [LEN_WIDTH-1:0]  len_q, idx_q;
  logic [SW-1:0]         shift_q;
  logic [DATA_WIDTH-1:0] mask_q;
  logic                  carry_q;
  logic                  acc_bit_q;
  logic                  illegal_q;
  logic [DATA_WIDTH-1:0] result_q;

  logic [ADDR_WIDTH-1:0] row_off;
  logic [DATA_WIDTH:0]   add_sum;
  logic [SW:0]           rot_back;
  logic [DATA_WIDTH-1:0] row_res;
  logic                  writes_row;
  logic                  last_row;
  logic                  xor_bit;
  logic                  and_bit;

  assign row_off    = ADDR_WIDTH'(idx_q);
  assign last_row   = (idx_q == len_q);
  assign writes_row = (op_q <= OP_ADD);
  assign add_sum    = {1'b0, sram_q_a_in} + {1'b0, sram_q_b_in} + (DATA_WIDTH+1)'(carry_q);
  // A shift by the full width yields zero, so shift 0 rotates to A unchanged.
  assign rot_back   = (SW+1)'(DATA_WIDTH) - {1'b0, shift_q};
  assign xor_bit    = acc_bit_q ^ (^sram_q_a_in);
  assign and_bit    = acc_bit_q & (&(sram_q_a_in | ~mask_q));

  always_comb begin
    row_res = '0;
    case (op_q)
      OP_OR:   row_res = sram_q_a_in | sram_q_b_in;
      OP_AND:  row_res = sram_q_a_in & sram_q_b_in;
      OP_XOR:  row_res = sram_q_a_in ^ sram_q_b_in;
      OP_MOV:  row_res = sram_q_a_in;
      OP_NOT:  row_res = ~sram_q_a_in;
      OP_SHL:  row_res = sram_q_a_in << shift_q;
      OP_SHR:  row_res = sram_q_a_in >> shift_q;
      OP_ROTL: row_res = (sram_q_a_in << shift_q) | (sram_q_a_in >> rot_back);
      OP_ADD:  row_res = add_sum[DATA_WIDTH-1:0];
      default: row_res = '0;
    endcase
  end

`ifdef CIM_POPCOUNT_EN
  logic [DATA_WIDTH-1:0] pop_q;
  logic [DATA_WIDTH:0]   pop_sum;
  logic [DATA_WIDTH-1:0] pop_next;

  function automatic logic [SW:0] popcnt(input logic [DATA_WIDTH-1:0] v);
    logic [SW:0] cnt;
    cnt = '0;
    for (int k = 0; k < DATA_WIDTH; k++) cnt = cnt + (SW+1)'(v[k]);
    return cnt;
  endfunction

  assign pop_sum  = {1'b0, pop_q} + (DATA_WIDTH+1)'(popcnt(sram_q_a_in & mask_q));
  assign pop_next = pop_sum[DATA_WIDTH] ? '1 : pop_sum[DATA_WIDTH-1:0];

  always_ff @(posedge sys_clk_in or posedge sys_reset_in) begin
    if (sys_reset_in) pop_q <= '0;
    else if (state == IDLE) pop_q <= '0;
    else if (state == EXE && op_q == OP_POP) pop_q <= pop_next;
  end
`endif

  always_ff @(posedge sys_clk_in or posedge sys_reset_in) begin
    if (sys_reset_in) begin
      state     <= IDLE;
      op_q      <= '0;
      src_a_q   <= '0;
      src_b_q   <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      mask_q    <= '0;
      carry_q   <= 1'b0;
      acc_bit_q <= 1'b0;
      illegal_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (cmd_valid_in) begin
            op_q      <= cmd_op_in;
            src_a_q   <= cmd_src_a_in;
            src_b_q   <= cmd_src_b_in;
            dst_q     <= cmd_dst_in;
            len_q     <= cmd_len_in;
            shift_q   <= cmd_shift_in;
            mask_q    <= cmd_mask_in;
            idx_q     <= '0;
            carry_q   <= 1'b0;
            acc_bit_q <= (cmd_op_in == OP_ANDR);
            illegal_q <= (cmd_op_in > OP_MAX);
          end
        end
        EXE: begin
          if (!last_row) idx_q <= idx_q + LEN_WIDTH'(1);
          if (op_q <= OP_ROTL) begin
            result_q <= row_res;
          end else begin
            case (op_q)
              OP_ADD: begin
                carry_q <= add_sum[DATA_WIDTH];
                if (last_row) result_q <= DATA_WIDTH'(add_sum[DATA_WIDTH]);
              end
              OP_XORR: begin
                acc_bit_q <= xor_bit;
                if (last_row) result_q <= DATA_WIDTH'(xor_bit);
              end
              OP_ANDR: begin
                acc_bit_q <= and_bit;
                if (last_row) result_q <= DATA_WIDTH'(and_bit);
              end
`ifdef CIM_POPCOUNT_EN
              OP_POP: begin
                if (last_row) result_q <= pop_next;
              end
`endif
              default: begin
                if (last_row) result_q <= '0;
              end
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt       = state;
    cmd_ready_out   = 1'b0;
    busy_out        = 1'b0;
    done_out        = 1'b0;
    error_out       = 1'b0;
    sram_addr_a_out = '0;
    sram_addr_b_out = '0;
    sram_data_a_out = '0;
    sram_wren_a_out = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready_out = 1'b1;
        if (cmd_valid_in) state_nxt = RD;
      end
      RD: begin
        busy_out        = 1'b1;
        sram_addr_a_out = src_a_q + row_off;
        sram_addr_b_out = src_b_q + row_off;
        state_nxt       = EXE;
      end
      EXE: begin
        busy_out        = 1'b1;
        sram_addr_b_out = src_b_q + row_off;
        // Writing back on port A in EXE means the next RD sees the updated row.
        if (writes_row) begin
          sram_addr_a_out = dst_q + row_off;
          sram_data_a_out = row_res;
          sram_wren_a_out = 1'b1;
        end else begin
          sram_addr_a_out = src_a_q + row_off;
        end
        state_nxt = last_row ? DONE : RD;
      end
      DONE: begin
        busy_out  = 1'b1;
        done_out  = 1'b1;
        error_out = illegal_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign result_out = result_q;

endmodule

// File: tb/tb_cim_vector_datapath.sv
// Scoreboard bench for cim_vector_datapath: random and directed commands checked against a row-by-row reference model.
module tb_cim_vector_datapath;

  localparam int W  = 32;
  localparam int AW = 8;
  localparam int LW = 4;
  localparam int SW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid_in = 1'b0;
  logic          cmd_ready_out;
  logic [3:0]    cmd_op_in = '0;
  logic [AW-1:0] cmd_src_a_in = '0, cmd_src_b_in = '0, cmd_dst_in = '0;
  logic [LW-1:0] cmd_len_in = '0;
  logic [SW-1:0] cmd_shift_in = '0;
  logic [W-1:0]  cmd_mask_in = '0;
  logic [AW-1:0] sram_addr_a_out, sram_addr_b_out;
  logic [W-1:0]  sram_data_a_out;
  logic          sram_wren_a_out;
  logic [W-1:0]  sram_q_a_in = '0, sram_q_b_in = '0;
  logic          busy_out, done_out, error_out;
  logic [W-1:0]  result_out;

  cim_vector_datapath #(.DATA_WIDTH(W), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .sys_clk_in(clk), .sys_reset_in(rst),
    .cmd_valid_in(cmd_valid_in), .cmd_ready_out(cmd_ready_out),
    .cmd_op_in(cmd_op_in), .cmd_src_a_in(cmd_src_a_in), .cmd_src_b_in(cmd_src_b_in),
    .cmd_dst_in(cmd_dst_in), .cmd_len_in(cmd_len_in), .cmd_shift_in(cmd_shift_in),
    .cmd_mask_in(cmd_mask_in),
    .sram_addr_a_out(sram_addr_a_out), .sram_addr_b_out(sram_addr_b_out),
    .sram_data_a_out(sram_data_a_out), .sram_wren_a_out(sram_wren_a_out),
    .sram_q_a_in(sram_q_a_in), .sram_q_b_in(sram_q_b_in),
    .busy_out(busy_out), .done_out(done_out), .error_out(error_out),
    .result_out(result_out)
  );

  // Clock, cycle counter and a one-cycle-latency dual-port SRAM.
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [W-1:0] mem     [256];
  logic [W-1:0] ref_mem [256];

  always @(posedge clk) begin
    if (sram_wren_a_out) mem[sram_addr_a_out] <= sram_data_a_out;
    sram_q_a_in <= mem[sram_addr_a_out];
    sram_q_b_in <= mem[sram_addr_b_out];
  end

  // Scoreboard state.
  logic [W-1:0]    exp_q[$];
  logic            exp_err_q[$];
  int              exp_cyc_q[$];
  logic [AW+W-1:0] wr_q[$];
  int vectors = 0;
  int miscompares = 0;
  int accept_cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: applies the command row by row to ref_mem with plain arithmetic.
  task automatic model_cmd(input logic [3:0] op, input logic [AW-1:0] a, input logic [AW-1:0] b,
                           input logic [AW-1:0] d, input int rows, input logic [SW-1:0] sh,
                           input logic [W-1:0] mask, input int len, input bit push_done);
    logic [W-1:0] av, bv, row, res;
    logic [W:0]   s;
    logic [AW-1:0] ra, rb, rd;
    logic carry, xr, ar, err;
    longint pc;
    carry = 0; xr = 0; ar = 1; pc = 0; res = '0; err = 0;
    for (int i = 0; i < rows; i++) begin
      ra = a + AW'(i); rb = b + AW'(i); rd = d + AW'(i);
      av = ref_mem[ra]; bv = ref_mem[rb]; row = '0;
      case (op)
        4'd0: row = av | bv;
        4'd1: row = av & bv;
        4'd2: row = av ^ bv;
        4'd3: row = av;
        4'd4: row = ~av;
        4'd5: row = av << sh;
        4'd6: row = av >> sh;
        4'd7: row = (av << sh) | (av >> (W - int'(sh)));
        4'd8: begin s = {1'b0, av} + {1'b0, bv} + {32'd0, carry}; row = s[W-1:0]; carry = s[W]; end
        4'd9: xr = xr ^ (^av);
        4'd10: ar = ar & (&(av | ~mask));
        4'd11: pc = pc + $countones(av & mask);
        default: ;
      endcase
      if (op <= 4'd8) begin
        ref_mem[rd] = row;
        wr_q.push_back({rd, row});
        res = row;
      end
    end
    case (op)
      4'd8: res = {31'd0, carry};
      4'd9: res = {31'd0, xr};
      4'd10: res = {31'd0, ar};
`ifdef CIM_POPCOUNT_EN
      4'd11: res = (pc > 64'hFFFF_FFFF) ? '1 : pc[W-1:0];
`else
      4'd11: begin res = '0; err = 1; end
`endif
      default: if (op > 4'd8) begin res = '0; err = 1; end
    endcase
    if (push_done) begin
      exp_q.push_back(res);
      exp_err_q.push_back(err);
      // Counting the RD cycle after acceptance as cycle 1, DONE is cycle 2*(len+1)+1.
      exp_cyc_q.push_back(accept_cyc + 2 * (len + 1));
    end
  endtask

  // Monitor: checks every SRAM write and every completion against the queues.
  always @(negedge clk) begin
    if (sram_wren_a_out) begin
      if (wr_q.size() == 0) chk("unexpected_write", {sram_addr_a_out, sram_data_a_out}, 64'hDEAD);
      else chk("write", {sram_addr_a_out, sram_data_a_out}, wr_q.pop_front());
    end
    if (done_out) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        chk("result", result_out, exp_q.pop_front());
        chk("error", error_out, exp_err_q.pop_front());
        chk("latency", cyc, exp_cyc_q.pop_front());
        chk("busy_in_done", {busy_out, cmd_ready_out}, 2'b10);
      end
    end
  end

  // Driver tasks.
  task automatic drive(input logic [3:0] op, input logic [AW-1:0] a, input logic [AW-1:0] b,
                       input logic [AW-1:0] d, input logic [LW-1:0] len, input logic [SW-1:0] sh,
                       input logic [W-1:0] mask);
    cmd_op_in = op; cmd_src_a_in = a; cmd_src_b_in = b; cmd_dst_in = d;
    cmd_len_in = len; cmd_shift_in = sh; cmd_mask_in = mask; cmd_valid_in = 1'b1;
  endtask

  task automatic accept_and_model(input int rows, input bit push_done);
    logic [3:0] op; logic [AW-1:0] a, b, d; logic [LW-1:0] len; logic [SW-1:0] sh; logic [W-1:0] mask;
    op = cmd_op_in; a = cmd_src_a_in; b = cmd_src_b_in; d = cmd_dst_in;
    len = cmd_len_in; sh = cmd_shift_in; mask = cmd_mask_in;
    @(posedge clk); #1;
    accept_cyc = cyc;
    cmd_valid_in = 1'b0;
    cmd_op_in = 4'($urandom); cmd_src_a_in = 8'($urandom); cmd_src_b_in = 8'($urandom);
    cmd_dst_in = 8'($urandom); cmd_len_in = 4'($urandom); cmd_shift_in = 5'($urandom);
    cmd_mask_in = $urandom;
    model_cmd(op, a, b, d, (rows < 0) ? int'(len) + 1 : rows, sh, mask, int'(len), push_done);
  endtask

  task automatic send(input logic [3:0] op, input logic [AW-1:0] a, input logic [AW-1:0] b,
                      input logic [AW-1:0] d, input logic [LW-1:0] len, input logic [SW-1:0] sh,
                      input logic [W-1:0] mask);
    int t;
    @(negedge clk);
    drive(op, a, b, d, len, sh, mask);
    t = 0;
    while (!cmd_ready_out && t < 200) begin @(negedge clk); t++; end
    if (!cmd_ready_out) begin
      chk("ready_timeout", 64'd0, 64'd1);
      cmd_valid_in = 1'b0;
    end else begin
      accept_and_model(-1, 1'b1);
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || !cmd_ready_out) && t < 2000) begin @(negedge clk); t++; end
    if (t >= 2000) chk("idle_timeout", 64'd0, 64'd1);
    @(negedge clk);
  endtask

  task automatic set_row(input logic [AW-1:0] a, input logic [W-1:0] v);
    mem[a] = v; ref_mem[a] = v;
  endtask

  logic [W-1:0] snap [8];

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = $urandom; ref_mem[i] = mem[i];
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", cmd_ready_out, 1);
    chk("rst_flags", {busy_out, done_out, error_out, sram_wren_a_out}, 0);
    chk("rst_result", result_out, 0);
    chk("rst_addr", {sram_addr_a_out, sram_addr_b_out}, 0);
    chk("rst_data", sram_data_a_out, 0);
    @(negedge clk); rst = 1'b0;

    // XOR, single row
    set_row(8'h10, 32'hF0F0F0F0); set_row(8'h20, 32'hFF00FF00);
    send(4'd2, 8'h10, 8'h20, 8'h30, 4'd0, 5'd0, 32'd0);
    wait_idle();
    chk("xor_row", mem[8'h30], 32'h0FF00FF0);

    // ADD with carry across two rows
    set_row(8'h40, 32'hFFFFFFFF); set_row(8'h41, 32'h0);
    set_row(8'h50, 32'h1);        set_row(8'h51, 32'h0);
    send(4'd8, 8'h40, 8'h50, 8'h60, 4'd1, 5'd0, 32'd0);
    wait_idle();
    chk("add_row0", mem[8'h60], 32'h0);
    chk("add_row1", mem[8'h61], 32'h1);
    chk("add_carry", result_out, 32'h0);

    // ROTL with source address wrap
    set_row(8'hFF, 32'h80000001); set_row(8'h00, 32'h12345678);
    send(4'd7, 8'hFF, 8'h00, 8'h70, 4'd1, 5'd4, 32'd0);
    wait_idle();
    chk("rotl_row0", mem[8'h70], 32'h00000018);
    chk("rotl_wrap", mem[8'h71], 32'h23456781);

    // Masked AND-reduce
    set_row(8'h80, 32'h1234FFFF);
    send(4'd10, 8'h80, 8'h00, 8'h00, 4'd0, 5'd0, 32'h0000FFFF);
    wait_idle();
    chk("andr_one", result_out, 32'd1);
    set_row(8'h80, 32'h1234FFFE);
    send(4'd10, 8'h80, 8'h00, 8'h00, 4'd0, 5'd0, 32'h0000FFFF);
    wait_idle();
    chk("andr_zero", result_out, 32'd0);

    // Illegal opcode
    send(4'd15, 8'h01, 8'h02, 8'h03, 4'd2, 5'd0, 32'd0);
    wait_idle();
    chk("illegal_result", result_out, 32'd0);

    // Overlapping copy propagates the first row
    set_row(8'h90, 32'hCAFEBABE);
    send(4'd3, 8'h90, 8'h00, 8'h91, 4'd3, 5'd0, 32'd0);
    wait_idle();
    chk("overlap_last", mem[8'h94], 32'hCAFEBABE);

    // Random commands
    for (int n = 0; n < 60; n++) begin
      send(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), 8'($urandom),
           4'($urandom_range(0, 4)), 5'($urandom), $urandom);
    end
    wait_idle();

    // Reset during EXE of row 2 of a len-7 command
    for (int i = 0; i < 8; i++) snap[i] = mem[8'hC0 + 8'(i)];
    @(negedge clk);
    drive(4'd0, 8'hA0, 8'hB0, 8'hC0, 4'd7, 5'd0, 32'd0);
    accept_and_model(2, 1'b0);
    repeat (5) @(posedge clk);
    #2;
    chk("pre_reset_wren", sram_wren_a_out, 1);
    rst = 1'b1;
    #1;
    chk("abort_wren", sram_wren_a_out, 0);
    chk("abort_ready", cmd_ready_out, 1);
    chk("abort_busy", busy_out, 0);
    chk("abort_addr", sram_addr_a_out, 0);
    drive(4'd1, 8'h10, 8'h20, 8'hD0, 4'd0, 5'd0, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    accept_and_model(-1, 1'b1);
    chk("first_edge_accept", busy_out, 1);
    for (int i = 2; i < 8; i++) chk("abort_no_write", mem[8'hC0 + 8'(i)], snap[i]);
    wait_idle();

    chk("writes_drained", wr_q.size(), 0);
    chk("dones_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
